phase_ctrl: RTL

- Multi-cycle control FSM for the 16-bit CPU.
- Steps each instruction through five phases: P1 fetch, P2 register read, P3 ALU/shifter, P4 memory, P5 writeback.
- Owns the condition-code register (S,Z,C,V) that latches the calc unit's code output, and evaluates branch conditions.
- Sits between the instruction register/decoder and the register file, memory, PC and ALU.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/br_cond_eval.sv | 33 +++
 rtl/phase_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU:
// opcode classes, op3/op2/cond codes and the phase FSM states.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P2,
        S_P3,
        S_P4,
        S_P5
    } state_t;

    localparam logic [1:0] OP1_LD  = 2'b00;
    localparam logic [1:0] OP1_ST  = 2'b01;
    localparam logic [1:0] OP1_IMM = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [3:0] OP3_ADD = 4'b0000;
    localparam logic [3:0] OP3_SUB = 4'b0001;
    localparam logic [3:0] OP3_AND = 4'b0010;
    localparam logic [3:0] OP3_OR  = 4'b0011;
    localparam logic [3:0] OP3_XOR = 4'b0100;
    localparam logic [3:0] OP3_CMP = 4'b0101;
    localparam logic [3:0] OP3_MOV = 4'b0110;
    localparam logic [3:0] OP3_SLL = 4'b1000;
    localparam logic [3:0] OP3_SLR = 4'b1001;
    localparam logic [3:0] OP3_SRL = 4'b1010;
    localparam logic [3:0] OP3_SRA = 4'b1011;
    localparam logic [3:0] OP3_IN  = 4'b1100;
    localparam logic [3:0] OP3_OUT = 4'b1101;
    localparam logic [3:0] OP3_HLT = 4'b1111;

    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BC  = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    // ALU/shift ops whose flags are kept in the condition codes.
    function automatic logic op3_sets_ccr(input logic [3:0] op3);
        return (op3 inside {[OP3_ADD:OP3_CMP], [OP3_SLL:OP3_SRA]});
    endfunction

    // ALU-class ops that produce a register result.
    function automatic logic op3_writes_reg(input logic [3:0] op3);
        return (op3 inside {[OP3_ADD:OP3_XOR], OP3_MOV,
                            [OP3_SLL:OP3_SRA], OP3_IN});
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Conditional-branch evaluator: decides taken from the
// 3-bit condition code and the latched {S,Z,C,V} flags.
module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [3:0] ccr,
    output logic       taken
);

    logic s_flag;
    logic z_flag;
    logic v_flag;
    logic unused_c;

    assign s_flag   = ccr[3];
    assign z_flag   = ccr[2];
    assign v_flag   = ccr[0];
    assign unused_c = ccr[1];

    // Signed compare results derive from S^V; reserved codes never branch.
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            COND_BE:  taken = z_flag;
            COND_BLT: taken = s_flag ^ v_flag;
            COND_BLE: taken = z_flag | (s_flag ^ v_flag);
            COND_BNE: taken = ~z_flag;
            default:  taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/phase_ctrl.sv
// Five-phase instruction sequencer with condition-code register
// and branch resolution for the 16-bit multi-cycle CPU.
module phase_ctrl
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        stop,
    input  logic [15:0] instr,
    input  logic [3:0]  alu_code,
    output logic [4:0]  phase,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel_br,
    output logic        mem_re,
    output logic        mem_we,
    output logic        reg_we,
    output logic [3:0]  ccr,
    output logic        halted
);

    localparam logic [2:0] WAIT_LAST = MEM_WAIT[2:0];

    state_t     state;
    state_t     state_nx;
    logic [2:0] wcnt;
    logic       stop_flag;

    logic [1:0] op1;
    logic [2:0] op2;
    logic [2:0] cond;
    logic [3:0] op3;
    logic       unused_bits;

    logic       is_ld;
    logic       is_st;
    logic       is_mem;
    logic       is_hlt;
    logic       sets_ccr;
    logic       writes_reg;
    logic       cond_ok;
    logic       br_take;
    logic       wait_done;
    logic       p4_last;

    assign op1         = instr[15:14];
    assign op2         = instr[13:11];
    assign cond        = instr[10:8];
    assign op3         = instr[7:4];
    assign unused_bits = ^instr[3:0];

    assign is_ld    = (op1 == OP1_LD);
    assign is_st    = (op1 == OP1_ST);
    assign is_mem   = is_ld | is_st;
    assign is_hlt   = (op1 == OP1_ALU) && (op3 == OP3_HLT);
    assign sets_ccr = (op1 == OP1_ALU) && op3_sets_ccr(op3);

    assign writes_reg = ((op1 == OP1_ALU) && op3_writes_reg(op3))
                      | is_ld
                      | ((op1 == OP1_IMM) && (op2 == OP2_LI));

    br_cond_eval u_br (
        .cond  (cond),
        .ccr   (ccr),
        .taken (cond_ok)
    );

    assign br_take = (op1 == OP1_IMM)
                   && ((op2 == OP2_B) || ((op2 == OP2_BC) && cond_ok));

    assign wait_done = (wcnt == WAIT_LAST);
    assign p4_last   = ~is_mem | wait_done;

    // Phase sequencing; stop is folded in at the P5 exit.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (run) state_nx = S_P1;
            S_P1:   if (wait_done) state_nx = S_P2;
            S_P2:   state_nx = S_P3;
            S_P3:   state_nx = S_P4;
            S_P4:   if (p4_last) state_nx = S_P5;
            S_P5: begin
                if (is_hlt || stop_flag || stop) begin
                    state_nx = S_IDLE;
                end else begin
                    state_nx = S_P1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // State, wait counter, sticky stop request and condition codes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wcnt      <= 3'd0;
            stop_flag <= 1'b0;
            ccr       <= 4'd0;
        end else begin
            state <= state_nx;
            if (state_nx == state && (state == S_P1 || state == S_P4)) begin
                wcnt <= wcnt + 3'd1;
            end else begin
                wcnt <= 3'd0;
            end
            if (state == S_IDLE) begin
                stop_flag <= run & stop;
            end else if (state == S_P5) begin
                stop_flag <= 1'b0;
            end else begin
                stop_flag <= stop_flag | stop;
            end
            if (state == S_P3 && sets_ccr) begin
                ccr <= alu_code;
            end
        end
    end

    // Per-phase strobes; everything is quiet in a reset cycle.
    always_comb begin
        phase     = 5'b00000;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel_br = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        reg_we    = 1'b0;
        halted    = 1'b1;
        if (rst_n) begin
            halted = (state == S_IDLE);
            unique case (state)
                S_P1: begin
                    phase  = 5'b00001;
                    ir_we  = wait_done;
                    mem_re = wait_done;
                end
                S_P2: phase = 5'b00010;
                S_P3: phase = 5'b00100;
                S_P4: begin
                    phase  = 5'b01000;
                    mem_re = is_ld;
                    mem_we = is_st & wait_done;
                end
                S_P5: begin
                    phase     = 5'b10000;
                    pc_we     = 1'b1;
                    pc_sel_br = br_take;
                    reg_we    = writes_reg;
                end
                default: phase = 5'b00000;
            endcase
        end
    end

endmodule
